// File: rtl/intersection_scheduler_if.sv
// rtl/intersection_scheduler_if.sv - sensor inputs and lamp/camera outputs of the intersection scheduler
// Optional PED_WALK_EN adds the pedestrian request and walk signals.
interface intersection_scheduler_if;
    logic       side_req;
    logic       main_car;
    logic       side_car;
    logic [2:0] main_lamp;
    logic [2:0] side_lamp;
    logic       cam_main;
    logic       cam_side;
    logic [2:0] phase;
`ifdef PED_WALK_EN
    logic       ped_req;
    logic       walk;
`endif

    modport slave (
        input  side_req, main_car, side_car,
`ifdef PED_WALK_EN
        input  ped_req,
        output walk,
`endif
        output main_lamp, side_lamp, cam_main, cam_side, phase
    );

    modport master (
        output side_req, main_car, side_car,
`ifdef PED_WALK_EN
        output ped_req,
        input  walk,
`endif
        input  main_lamp, side_lamp, cam_main, cam_side, phase
    );
endinterface

// File: rtl/intersection_scheduler.sv
// rtl/intersection_scheduler.sv - two-road intersection sequencer with lamps and red-light camera triggers
// Optional macro PED_WALK_EN adds ped_req/walk and the WALK parameter.
module intersection_scheduler #(
    parameter int TW         = 8,
    parameter int MIN_GREEN  = 10,
    parameter int YELLOW     = 3,
    parameter int ALL_RED    = 2,
    parameter int SIDE_GREEN = 8
`ifdef PED_WALK_EN
    ,
    parameter int WALK       = 12
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    intersection_scheduler_if.slave bus
);
    localparam logic [2:0] S_MG  = 3'd0;
    localparam logic [2:0] S_MY  = 3'd1;
    localparam logic [2:0] S_AR1 = 3'd2;
    localparam logic [2:0] S_SG  = 3'd3;
    localparam logic [2:0] S_SY  = 3'd4;
    localparam logic [2:0] S_AR2 = 3'd5;

    localparam logic [2:0] L_RED    = 3'b100;
    localparam logic [2:0] L_YELLOW = 3'b010;
    localparam logic [2:0] L_GREEN  = 3'b001;

    localparam logic [TW-1:0] T_MG  = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] T_Y   = TW'(YELLOW - 1);
    localparam logic [TW-1:0] T_AR  = TW'(ALL_RED - 1);
    localparam logic [TW-1:0] T_SG  = TW'(SIDE_GREEN - 1);
    localparam logic [TW-1:0] T_MAX = {TW{1'b1}};

    logic [2:0]    state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic          pend, pend_n;
    logic          enter, enter_sg;
    logic          req_any;
    logic [TW-1:0] sg_last;
    logic [2:0]    main_lamp_n, side_lamp_n;

`ifdef PED_WALK_EN
    localparam int WALK_LEN = (WALK > SIDE_GREEN) ? WALK : SIDE_GREEN;
    localparam logic [TW-1:0] T_SGW = TW'(WALK_LEN - 1);

    logic ped_pend, ped_pend_n;
    logic walk_n;

    assign req_any = pend | ped_pend;
    // walk is already registered for the whole SG, so it also selects SG length
    assign sg_last = bus.walk ? T_SGW : T_SG;
`else
    assign req_any = pend;
    assign sg_last = T_SG;
`endif

    always_comb begin
        state_n = state;
        case (state)
            S_MG:    if (req_any && timer >= T_MG) state_n = S_MY;
            S_MY:    if (timer == T_Y)             state_n = S_AR1;
            S_AR1:   if (timer == T_AR)            state_n = S_SG;
            S_SG:    if (timer == sg_last)         state_n = S_SY;
            S_SY:    if (timer == T_Y)             state_n = S_AR2;
            S_AR2:   if (timer == T_AR)            state_n = S_MG;
            default:                               state_n = S_AR2;
        endcase
    end

    assign enter    = (state_n != state);
    assign enter_sg = enter && (state_n == S_SG);

    always_comb begin
        if (enter)
            timer_n = '0;
        else if (timer == T_MAX)
            timer_n = timer;
        else
            timer_n = timer + 1'b1;
    end

    // clear on SG entry takes priority over a coincident request
    always_comb begin
        pend_n = pend;
        if (enter_sg)
            pend_n = 1'b0;
        else if (bus.side_req && state != S_SG)
            pend_n = 1'b1;
    end

`ifdef PED_WALK_EN
    always_comb begin
        ped_pend_n = ped_pend;
        if (enter_sg)
            ped_pend_n = 1'b0;
        else if (bus.ped_req && state != S_SG)
            ped_pend_n = 1'b1;
    end

    always_comb begin
        walk_n = 1'b0;
        if (enter_sg)
            walk_n = ped_pend;
        else if (state_n == S_SG)
            walk_n = bus.walk;
    end
`endif

    // lamps decode the next state so they change on the same edge as phase
    always_comb begin
        main_lamp_n = L_RED;
        side_lamp_n = L_RED;
        case (state_n)
            S_MG: main_lamp_n = L_GREEN;
            S_MY: main_lamp_n = L_YELLOW;
            S_SG: side_lamp_n = L_GREEN;
            S_SY: side_lamp_n = L_YELLOW;
            default: begin
                main_lamp_n = L_RED;
                side_lamp_n = L_RED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_AR2;
            timer         <= '0;
            pend          <= 1'b0;
            bus.main_lamp <= L_RED;
            bus.side_lamp <= L_RED;
            bus.cam_main  <= 1'b0;
            bus.cam_side  <= 1'b0;
        end else begin
            state         <= state_n;
            timer         <= timer_n;
            pend          <= pend_n;
            bus.main_lamp <= main_lamp_n;
            bus.side_lamp <= side_lamp_n;
            bus.cam_main  <= bus.main_car & bus.main_lamp[2];
            bus.cam_side  <= bus.side_car & bus.side_lamp[2];
        end
    end

`ifdef PED_WALK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_pend <= 1'b0;
            bus.walk <= 1'b0;
        end else begin
            ped_pend <= ped_pend_n;
            bus.walk <= walk_n;
        end
    end
`endif

    assign bus.phase = state;
endmodule
